// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key-schedule generator and the cipher
// round datapath.
//   round_key_t  : 128-bit round key
//   kexp_state_t : key-expansion controller states
//   nk_of/nr_of  : key words and round count for a given key length
//   xtime        : multiply by x in GF(2^8); also steps the Rcon register
//   RCON_START   : Rcon value for the first key-dependent word
//   RCON_POLY    : reduction term applied when the MSB shifts out (80 -> 1b)
package aes_pkg;

    typedef logic [127:0] round_key_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } kexp_state_t;

    localparam logic [7:0] RCON_START = 8'h01;
    localparam logic [7:0] RCON_POLY  = 8'h1b;

    function automatic int nk_of(input int key_bits);
        return key_bits / 32;
    endfunction

    function automatic int nr_of(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational. Shared with the cipher datapath.
//   i_byte : input byte
//   o_byte : substituted byte
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 is the most significant byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128/192/256 key-schedule generator. One schedule word per clock, one
// 128-bit round key streamed out per four words, in encryption order.
//
// Parameter
//   KEY_BITS : 128, 192 or 256
// Ports
//   CLK, RST  : clock, synchronous active-high reset
//   start     : begin an expansion of key (taken when idle, or on the final word)
//   key       : cipher key, w[0] in the top 32 bits
//   busy      : expansion running
//   rk_valid  : one-cycle strobe qualifying rk / rk_idx
//   rk        : round key, w[4k] in bits [127:96]
//   rk_idx    : round number k
//   done      : pulses with the last round key
//   rd_idx    : stored round-key read index
//   rd_key    : stored round key, one cycle after rd_idx
// Build option
//   AES_KEYEXP_STORE_EN : keeps every round key in a register file for
//                         reverse-order access; without it rd_key is 0.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start, no words produced
// ST_RUN  | producing one schedule word per cycle, r_cnt = word index
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key,
    output logic                busy,
    output logic                rk_valid,
    output logic [127:0]        rk,
    output logic [3:0]          rk_idx,
    output logic                done,
    input  logic [3:0]          rd_idx,
    output logic [127:0]        rd_key
);

    localparam int         NK        = nk_of(KEY_BITS);
    localparam int         NR        = nr_of(KEY_BITS);
    localparam logic [5:0] LAST_WORD = 6'(4 * (NR + 1) - 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_key_expand: KEY_BITS must be 128, 192 or 256");
    end

    kexp_state_t r_state;
    kexp_state_t w_state_nxt;
    logic        w_accept;
    logic        w_last;

    // r_win[0] is w[i-Nk], r_win[NK-1] is w[i-1].
    logic [31:0] r_win [0:NK-1];
    logic [5:0]  r_cnt;
    logic [2:0]  r_phase;
    logic [7:0]  r_rcon;
    round_key_t  r_rk;
    logic [3:0]  r_rk_idx;
    logic        r_rk_valid;
    logic        r_done;

    logic        w_first;
    logic        w_rot_phase;
    logic        w_sub_phase;
    logic [31:0] w_prev;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub_out;
    logic [31:0] w_t;
    logic [31:0] w_new;

    assign w_last = (r_state == ST_RUN) && (r_cnt == LAST_WORD);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A start seen on the final word chains straight into the next key.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_accept    = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    if (start) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_first     = (r_cnt < 6'(NK));
    assign w_rot_phase = !w_first && (r_phase == 3'd0);
    assign w_sub_phase = !w_first && (NK == 8) && (r_phase == 3'd4);
    assign w_prev      = r_win[NK-1];
    assign w_sub_in    = w_rot_phase ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (w_sub_in[8*b +: 8]),
            .o_byte (w_sub_out[8*b +: 8])
        );
    end

    assign w_t = w_rot_phase ? (w_sub_out ^ {r_rcon, 24'h0}) :
                 w_sub_phase ? w_sub_out : w_prev;

    // While the key words are being emitted the window simply rotates, so
    // after Nk cycles it holds w[0..Nk-1] in order with no separate key copy.
    assign w_new = w_first ? r_win[0] : (r_win[0] ^ w_t);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int j = 0; j < NK; j++) begin
                r_win[j] <= '0;
            end
            r_cnt      <= '0;
            r_phase    <= '0;
            r_rcon     <= '0;
            r_rk       <= '0;
            r_rk_idx   <= '0;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            if (r_state == ST_RUN) begin
                for (int j = 0; j < NK - 1; j++) begin
                    r_win[j] <= r_win[j+1];
                end
                r_win[NK-1] <= w_new;
                r_cnt       <= r_cnt + 6'd1;
                r_phase     <= (r_phase == 3'(NK - 1)) ? 3'd0 : r_phase + 3'd1;
                if (w_rot_phase) begin
                    r_rcon <= xtime(r_rcon);
                end
                if (r_cnt[1:0] == 2'd3) begin
                    r_rk       <= {r_win[NK-3], r_win[NK-2], r_win[NK-1], w_new};
                    r_rk_idx   <= r_cnt[5:2];
                    r_rk_valid <= 1'b1;
                    r_done     <= w_last;
                end
            end
            if (w_accept) begin
                for (int j = 0; j < NK; j++) begin
                    r_win[j] <= key[KEY_BITS-1-32*j -: 32];
                end
                r_cnt   <= '0;
                r_phase <= '0;
                r_rcon  <= RCON_START;
            end
        end
    end

    assign busy     = (r_state == ST_RUN);
    assign rk_valid = r_rk_valid;
    assign rk       = r_rk;
    assign rk_idx   = r_rk_idx;
    assign done     = r_done;

`ifdef AES_KEYEXP_STORE_EN
    // Not reset: the keys must survive RST for the decryption rounds.
    round_key_t r_store [0:NR];
    round_key_t r_rd_key;

    always_ff @(posedge CLK) begin
        if (r_rk_valid) begin
            r_store[r_rk_idx] <= r_rk;
        end
        if (rd_idx <= 4'(NR)) begin
            r_rd_key <= r_store[rd_idx];
        end else begin
            r_rd_key <= '0;
        end
    end

    assign rd_key = r_rd_key;
`else
    logic w_unused_rd_idx;
    assign w_unused_rd_idx = ^rd_idx;
    assign rd_key          = '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

    logic               CLK = 1'b0;
    logic               RST;
    logic [2:0]         start_d;
    logic [127:0]       key128;
    logic [191:0]       key192;
    logic [255:0]       key256;
    logic [3:0]         rd_idx;
    logic [2:0]         busy_o;
    logic [2:0]         rkv_o;
    logic [2:0]         done_o;
    logic [2:0][127:0]  rk_o;
    logic [2:0][127:0]  rdk_o;
    logic [2:0][3:0]    idx_o;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] exp_rk   [0:14];
    logic [127:0] got_rk   [0:14];
    logic [255:0] next_key;

    always #5 CLK = ~CLK;

    aes_key_expand #(.KEY_BITS(128)) u_dut128 (
        .CLK(CLK), .RST(RST), .start(start_d[0]), .key(key128),
        .busy(busy_o[0]), .rk_valid(rkv_o[0]), .rk(rk_o[0]), .rk_idx(idx_o[0]),
        .done(done_o[0]), .rd_idx(rd_idx), .rd_key(rdk_o[0])
    );

    aes_key_expand #(.KEY_BITS(192)) u_dut192 (
        .CLK(CLK), .RST(RST), .start(start_d[1]), .key(key192),
        .busy(busy_o[1]), .rk_valid(rkv_o[1]), .rk(rk_o[1]), .rk_idx(idx_o[1]),
        .done(done_o[1]), .rd_idx(rd_idx), .rd_key(rdk_o[1])
    );

    aes_key_expand #(.KEY_BITS(256)) u_dut256 (
        .CLK(CLK), .RST(RST), .start(start_d[2]), .key(key256),
        .busy(busy_o[2]), .rk_valid(rkv_o[2]), .rk(rk_o[2]), .rk_idx(idx_o[2]),
        .done(done_o[2]), .rd_idx(rd_idx), .rd_key(rdk_o[2])
    );

    // ---------------- reference model: GF(2^8) arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int bit_i = 14; bit_i >= 8; bit_i--) begin
            if (p[bit_i]) p = p ^ (16'h011b << (bit_i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] tmp;
        tmp = {b, b} << n;
        return tmp[15:8];
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
    endfunction

    task automatic model(input int nk, input logic [255:0] k);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = k[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int kk = 0; kk <= nr; kk++) begin
            exp_rk[kk] = {w[4*kk], w[4*kk+1], w[4*kk+2], w[4*kk+3]};
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive_key(input int sel, input logic [255:0] k);
        case (sel)
            0:       key128 = k[255:128];
            1:       key192 = k[255:64];
            default: key256 = k;
        endcase
    endtask

    // mode 0: plain run; 1: extra start (new key) at E10; 2: chain next_key at
    // the final edge and leave start high; 3: run already accepted by mode 2.
    task automatic run_check(input int sel, input logic [255:0] k, input int mode);
        int nk;
        int nr;
        int len;
        int kk;
        logic exp_busy;
        nk  = 4 + 2 * sel;
        nr  = nk + 6;
        len = 4 * (nr + 1);
        model(nk, k);
        for (int j = 0; j < 15; j++) got_rk[j] = '0;
        if (mode != 3) begin
            drive_key(sel, k);
            start_d[sel] = 1'b1;
            @(posedge CLK);
            @(negedge CLK);
            start_d[sel] = 1'b0;
            checks++;
            if (busy_o[sel] !== 1'b1) begin
                errors++;
                $display("FAIL busy_after_start sel=%0d got=%b exp=1", sel, busy_o[sel]);
            end
        end
        for (int n = 1; n <= len; n++) begin
            @(negedge CLK);
            if (mode == 3 && n == 1) start_d[sel] = 1'b0;
            if (mode == 1 && n == 9) begin
                drive_key(sel, ~k);
                start_d[sel] = 1'b1;
            end
            if (mode == 1 && n == 10) start_d[sel] = 1'b0;
            if (mode == 2 && n == len - 1) begin
                drive_key(sel, next_key);
                start_d[sel] = 1'b1;
            end
            if (n % 4 == 0) begin
                kk = n / 4 - 1;
                got_rk[kk] = rk_o[sel];
                checks++;
                if (rkv_o[sel] !== 1'b1 || idx_o[sel] !== 4'(kk)) begin
                    errors++;
                    $display("FAIL rk_strobe sel=%0d n=%0d got valid=%b idx=%0d exp valid=1 idx=%0d",
                             sel, n, rkv_o[sel], idx_o[sel], kk);
                end
                checks++;
                if (rk_o[sel] !== exp_rk[kk]) begin
                    errors++;
                    $display("FAIL rk_value sel=%0d k=%0d got=%h exp=%h", sel, kk, rk_o[sel], exp_rk[kk]);
                end
                checks++;
                if (done_o[sel] !== (kk == nr)) begin
                    errors++;
                    $display("FAIL done sel=%0d k=%0d got=%b exp=%b", sel, kk, done_o[sel], (kk == nr));
                end
            end else begin
                checks++;
                if (rkv_o[sel] !== 1'b0 || done_o[sel] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_strobe sel=%0d n=%0d got valid=%b done=%b exp 0 0",
                             sel, n, rkv_o[sel], done_o[sel]);
                end
            end
            exp_busy = (n < len) || (mode == 2);
            checks++;
            if (busy_o[sel] !== exp_busy) begin
                errors++;
                $display("FAIL busy sel=%0d n=%0d got=%b exp=%b", sel, n, busy_o[sel], exp_busy);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (busy_o[s] !== 1'b0 || rkv_o[s] !== 1'b0 || done_o[s] !== 1'b0 ||
                rk_o[s] !== '0 || idx_o[s] !== 4'd0) begin
                errors++;
                $display("FAIL reset_state sel=%0d got busy=%b v=%b done=%b idx=%0d rk=%h exp all zero",
                         s, busy_o[s], rkv_o[s], done_o[s], idx_o[s], rk_o[s]);
            end
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < 2; r++) begin
                run_check(s, rand256(), 0);
                repeat (2) @(negedge CLK);
            end
        end
    endtask

    task automatic test_ignore_start();
        run_check(0, rand256(), 1);
        repeat (2) @(negedge CLK);
        run_check(2, rand256(), 1);
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s += 2) begin
            next_key = rand256();
            run_check(s, rand256(), 2);
            run_check(s, next_key, 3);
            repeat (2) @(negedge CLK);
        end
    endtask

    task automatic test_rst_abort();
        int seen;
        seen = 0;
        drive_key(0, rand256());
        start_d[0] = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start_d[0] = 1'b0;
        repeat (19) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (busy_o[0] !== 1'b0 || rkv_o[0] !== 1'b0 || done_o[0] !== 1'b0 ||
            rk_o[0] !== '0 || idx_o[0] !== 4'd0) begin
            errors++;
            $display("FAIL rst_abort_clear got busy=%b v=%b done=%b idx=%0d rk=%h exp all zero",
                     busy_o[0], rkv_o[0], done_o[0], idx_o[0], rk_o[0]);
        end
        repeat (60) begin
            @(negedge CLK);
            if (rkv_o[0] === 1'b1 || busy_o[0] === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_abort_quiet active_cycles got=%0d exp=0", seen);
        end
        run_check(0, rand256(), 0);
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_known();
        run_check(1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 0);
        checks++;
        if (got_rk[12] !== 128'he98ba06f448c773c8ecc720401002202) begin
            errors++;
            $display("FAIL known192_k12 got=%h exp=e98ba06f448c773c8ecc720401002202", got_rk[12]);
        end
        repeat (2) @(negedge CLK);
        run_check(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 0);
        checks++;
        if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) begin
            errors++;
            $display("FAIL known256_k14 got=%h exp=fe4890d1e6188d0b046df344706c631e", got_rk[14]);
        end
        repeat (2) @(negedge CLK);
        run_check(0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0);
        checks++;
        if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL known128_k1 got=%h exp=a0fafe1788542cb123a339392a6c7605", got_rk[1]);
        end
        checks++;
        if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL known128_k10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_store();
`ifdef AES_KEYEXP_STORE_EN
        rd_idx = 4'd10;
        @(negedge CLK);
        checks++;
        if (rdk_o[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL store_rd10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", rdk_o[0]);
        end
        rd_idx = 4'd0;
        @(negedge CLK);
        checks++;
        if (rdk_o[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            errors++;
            $display("FAIL store_rd0 got=%h exp=2b7e151628aed2a6abf7158809cf4f3c", rdk_o[0]);
        end
        rd_idx = 4'd15;
        @(negedge CLK);
        checks++;
        if (rdk_o[0] !== '0) begin
            errors++;
            $display("FAIL store_rd15 got=%h exp=0", rdk_o[0]);
        end
        rd_idx = 4'd14;
        @(negedge CLK);
        checks++;
        if (rdk_o[2] !== 128'hfe4890d1e6188d0b046df344706c631e || rdk_o[0] !== '0 || rdk_o[1] !== '0) begin
            errors++;
            $display("FAIL store_rd14 got256=%h got128=%h got192=%h exp256=fe4890d1e6188d0b046df344706c631e others=0",
                     rdk_o[2], rdk_o[0], rdk_o[1]);
        end
`else
        for (int r = 0; r < 16; r += 5) begin
            rd_idx = 4'(r);
            @(negedge CLK);
            for (int s = 0; s < 3; s++) begin
                checks++;
                if (rdk_o[s] !== '0) begin
                    errors++;
                    $display("FAIL rd_key_zero sel=%0d idx=%0d got=%h exp=0", s, r, rdk_o[s]);
                end
            end
        end
`endif
    endtask

    initial begin
        RST     = 1'b1;
        start_d = '0;
        key128  = '0;
        key192  = '0;
        key256  = '0;
        rd_idx  = '0;
        for (int x = 0; x < 256; x++) sbox_tab[x] = sbox_math(8'(x));
        test_reset();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_rst_abort();
        test_known();
        test_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
